// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags and a start/done handshake.
// MUL (shift-add) and SHLN/SHRN (one bit per cycle) run in the RUN state; every other op completes on its start edge.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic             zf,
  output logic             cf
);
  // Handshake: start is accepted only while busy=0 (IDLE, including the done
  // cycle); done pulses for exactly one cycle when c/hi/zf/cf are updated.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_SHLN = 4'h5;
  localparam logic [3:0] OP_SHRN = 4'h6;
  localparam logic [3:0] OP_NOP  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_SHR  = 4'hF;

  localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [CW-1:0]  ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               zf_q, zf_d, cf_q, cf_d;
  logic [WIDTH-1:0]   c_q, c_d, hi_q, hi_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [3:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  // Single-cycle datapath: bit WIDTH of wide is the carry/borrow/shifted-out bit.
  logic [WIDTH:0]   ext_a, ext_b, ext_ci, wide;
  logic [WIDTH-1:0] alu_c;
  logic             alu_cf;

  always_comb begin
    ext_a  = {1'b0, a};
    ext_b  = {1'b0, b};
    ext_ci = {{WIDTH{1'b0}}, cf_q};
    wide   = '0;
    case (opcode)
      OP_ADD:  wide = ext_a + ext_b;
      OP_SUB:  wide = ext_a - ext_b;
      OP_ADC:  wide = ext_a + ext_b + ext_ci;
      OP_SBB:  wide = ext_a - ext_b - ext_ci;
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~a};
      OP_INC:  wide = ext_a + ONE_W;
      OP_DEC:  wide = ext_a - ONE_W;
      OP_SHL:  wide = {a, 1'b0};
      OP_SHR:  wide = {a[0], 1'b0, a[WIDTH-1:1]};
      default: wide = '0;
    endcase
    alu_c  = wide[WIDTH-1:0];
    alu_cf = wide[WIDTH];
  end

  // Iteration steps: product register starts as {0, b} and shifts right each step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_out;

  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    mul_nxt = {mul_sum, prod_q[WIDTH-1:1]};
    if (op_q == OP_SHLN) begin
      sh_nxt = {opa_q[WIDTH-2:0], 1'b0};
      sh_out = opa_q[WIDTH-1];
    end else begin
      sh_nxt = {1'b0, opa_q[WIDTH-1:1]};
      sh_out = opa_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    hi_d    = hi_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    opa_d   = opa_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = opcode;
          opa_d = a;
          case (opcode)
            OP_MUL: begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = CW'(WIDTH);
              prod_d  = {{WIDTH{1'b0}}, b};
            end
            OP_SHLN, OP_SHRN: begin
              if (b[SHW-1:0] == '0) begin
                c_d    = a;
                hi_d   = '0;
                zf_d   = (a == '0);
                done_d = 1'b1;
              end else begin
                state_d = RUN;
                busy_d  = 1'b1;
                cnt_d   = CW'(b[SHW-1:0]);
              end
            end
            OP_NOP: done_d = 1'b1;
            default: begin
              c_d    = alu_c;
              hi_d   = '0;
              cf_d   = alu_cf;
              zf_d   = (alu_c == '0);
              done_d = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - ONE_CW;
        if (op_q == OP_MUL) prod_d = mul_nxt;
        else                opa_d  = sh_nxt;
        // Outputs change only on the final step; earlier steps stay internal.
        if (cnt_q == ONE_CW) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (op_q == OP_MUL) begin
            c_d  = mul_nxt[WIDTH-1:0];
            hi_d = mul_nxt[2*WIDTH-1:WIDTH];
            cf_d = (mul_nxt[2*WIDTH-1:WIDTH] != '0);
            zf_d = (mul_nxt == '0);
          end else begin
            c_d  = sh_nxt;
            hi_d = '0;
            cf_d = sh_out;
            zf_d = (sh_nxt == '0);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      hi_q    <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      opa_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      hi_q    <= hi_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      opa_q   <= opa_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;
  assign hi   = hi_q;
  assign zf   = zf_q;
  assign cf   = cf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): driver pushes expected {hi,c,zf,cf}, a negedge monitor pops on done.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int EW = 2 * W + 2;

  logic         clk, rst_n, start;
  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic         busy, done, zf, cf;
  logic [W-1:0] c, hi;

  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .hi(hi), .zf(zf), .cf(cf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result_hi_c_zf_cf", 32'({hi, c, zf, cf}), 32'(e));
      end
    end
  end

  // Driver: issue one op, expect done after lat edges with busy high for lat cycles.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ec, input logic [W-1:0] eh, input logic ezf,
                       input logic ecf, input int lat, input bit poke);
    int cycles, bcnt;
    exp_q.push_back({eh, ec, ezf, ecf});
    @(negedge clk);
    start = 1'b1; opcode = op; a = ia; b = ib;
    @(posedge clk); #1;
    start  = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    a      = W'($urandom_range(0, 255));
    b      = W'($urandom_range(0, 255));
    cycles = 0;
    bcnt   = 0;
    while (!done && cycles < lat + 4) begin
      if (busy) bcnt++;
      if (poke && cycles >= 2 && cycles <= 5) begin
        start = 1'b1; opcode = 4'h0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'(1));
    check("latency", 32'(cycles), 32'(lat));
    check("busy_cycles", 32'(bcnt), 32'(lat));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({busy, done, hi, c, zf, cf}), 32'(0));
    rst_n = 1'b1;

    // Arithmetic with stored carry
    do_op(4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1'b0); // ADD
    do_op(4'h2, 8'h10, 8'h20, 8'h31, 8'h00, 1'b0, 1'b0, 0, 1'b0); // ADC, cf_old=1
    do_op(4'h1, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b1, 0, 1'b0); // SUB
    do_op(4'h3, 8'h10, 8'h00, 8'h0F, 8'h00, 1'b0, 1'b0, 0, 1'b0); // SBB, cf_old=1
    do_op(4'hD, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 1'b0); // DEC_A
    // Multiplier, with ignored start pulses during RUN
    do_op(4'h4, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1, 8, 1'b1);
    do_op(4'hC, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1'b0); // INC_A clears hi
    do_op(4'h4, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b1, 1'b0, 8, 1'b0);
    // Shifts
    do_op(4'h5, 8'h81, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0, 3, 1'b0); // SHLN 3
    do_op(4'h6, 8'h81, 8'h01, 8'h40, 8'h00, 1'b0, 1'b1, 1, 1'b0); // SHRN 1
    do_op(4'h5, 8'h5A, 8'h08, 8'h5A, 8'h00, 1'b0, 1'b1, 0, 1'b0); // SHLN count 0
    do_op(4'h7, 8'h12, 8'h34, 8'h5A, 8'h00, 1'b0, 1'b1, 0, 1'b0); // NOP holds
    do_op(4'hE, 8'h81, 8'h00, 8'h02, 8'h00, 1'b0, 1'b1, 0, 1'b0); // SHL_A
    do_op(4'hF, 8'h81, 8'h00, 8'h40, 8'h00, 1'b0, 1'b1, 0, 1'b0); // SHR_A

    // Reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; opcode = 4'h4; a = 8'h37; b = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", 32'({busy, done, hi, c, zf, cf}), 32'(0));
    repeat (3) @(negedge clk);
    check("reset_hold", 32'({busy, done, hi, c, zf, cf}), 32'(0));
    rst_n = 1'b1;

    // Logic ops, each issued on the previous done cycle
    do_op(4'h8, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    do_op(4'h8, 8'hA5, 8'h0F, 8'h05, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    do_op(4'h9, 8'hA5, 8'h0F, 8'hAF, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    do_op(4'hA, 8'hA5, 8'h0F, 8'hAA, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    do_op(4'hB, 8'hA5, 8'h0F, 8'h5A, 8'h00, 1'b0, 1'b0, 0, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- WIDTH-parametrised successor to the 4-bit combinational ALU.
- Registered results and flags; start/done handshake.
- Adds arithmetic with a stored carry, an iterative shift-add multiplier, and multi-bit shifts that move one bit per cycle.
- Sits between the register file and the writeback mux of the datapath; the sequencer issues one operation at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), width of the shift-count field taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled only when busy=0.
- opcode  input  4  operation select; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B or shift count; sampled with start.
- busy  output  1  high while a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse in the cycle c/hi/zf/cf become valid.
- c  output  WIDTH  result; low half of the product for MUL.
- hi  output  WIDTH  high half of the product for MUL; 0 for all other ops.
- zf  output  1  registered zero flag.
- cf  output  1  registered carry/borrow flag; also the carry-in for ADC/SBB.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, c=0, hi=0, zf=0, cf=0.
- Reset mid-operation aborts immediately. No done pulse is produced, and no partial result is kept.
- Opcode map:
  - 0000 ADD
  - 0001 SUB
  - 0010 ADC
  - 0011 SBB
  - 0100 MUL
  - 0101 SHLN
  - 0110 SHRN
  - 0111 NOP
  - 1000 AND
  - 1001 OR
  - 1010 XOR
  - 1011 NOT_A
  - 1100 INC_A
  - 1101 DEC_A
  - 1110 SHL_A
  - 1111 SHR_A
- States: IDLE and RUN.
- Single-cycle ops (all except MUL, SHLN, SHRN):
  - start=1 in IDLE at edge N loads c/hi/zf/cf at edge N.
  - done=1 for the following cycle; busy stays 0.
- Multi-cycle ops:
  - start=1 in IDLE at edge N latches the operands, sets busy=1 and enters RUN.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the final step, c/hi/flags are loaded, busy=0, done=1, and the block returns to IDLE. Total latency is WIDTH cycles from the start edge to done.
  - SHLN/SHRN: one bit per cycle for count=b[SHW-1:0] cycles. Vacated bits are zero-filled.
  - Count=0 behaves as a single-cycle op: c=a, cf unchanged, no RUN.
- Back-to-back: start may be asserted in the same cycle that done is high, or in the first IDLE cycle. A new op issued then is accepted.
- start while busy=1 is ignored and is not queued. opcode/a/b changes during RUN have no effect.
- Outputs hold their last values between operations. NOP asserts done but leaves c/hi/zf/cf unchanged.
- Arithmetic and width rules (all WIDTH bits; results wrap modulo 2^WIDTH):
  - ADD: {cf,c}=a+b.
  - ADC: {cf,c}=a+b+cf_old.
  - SUB: c=a-b; cf=(a<b) unsigned.
  - SBB: c=a-b-cf_old; cf=borrow out.
  - INC_A: {cf,c}=a+1; c=0 and cf=1 when a is all ones.
  - DEC_A: c=a-1; cf=(a==0); c becomes all ones when a=0.
  - SHL_A/SHR_A: single-bit shift; cf=the bit shifted out.
  - SHLN/SHRN: cf=the last bit shifted out.
  - AND, OR, XOR, NOT_A: cf=0.
  - MUL: unsigned; {hi,c}=a*b; cf=(hi!=0).
  - hi=0 for every op except MUL and NOP.
- Zero flag: zf=({hi,c}==0), registered together with c.
- During RUN, c/hi/zf/cf keep their pre-op values until the done edge. Intermediate values are never visible.

Test Plan:
- WIDTH=8. Reset. ADD a=8'hFF, b=8'h01 -> next cycle c=8'h00, cf=1, zf=1, done=1 for one cycle, busy never 1. Then ADC a=8'h10, b=8'h20 -> c=8'h31, cf=0, zf=0.
- SUB a=8'h03, b=8'h05 -> c=8'hFE, cf=1. Then SBB a=8'h10, b=8'h00 -> c=8'h0F, cf=0. Then DEC_A a=8'h00 -> c=8'hFF, cf=1.
- MUL a=8'hFF, b=8'hFF -> busy=1 for 8 cycles, start pulses issued during that window are ignored. done arrives 8 cycles after the start edge with hi=8'hFE, c=8'h01, cf=1. MUL a=8'h00, b=8'h7F -> {hi,c}=0, zf=1, cf=0.
- SHLN a=8'b1000_0001, b=3 -> busy=1 for 3 cycles; then c=8'b0000_1000, cf=0. SHRN a=8'h81, b=1 -> c=8'h40, cf=1. SHLN with b=0 -> single-cycle, c=a, cf unchanged.
- Start MUL, then pull rst_n low 3 cycles later -> outputs clear asynchronously, no done pulse. After release, an AND with a=8'hF0, b=8'h3C gives c=8'h30.
- Logic ops AND/OR/XOR/NOT_A with a=8'hA5, b=8'h0F -> c=8'h05/8'hAF/8'hAA/8'h5A, cf=0, hi=0. Back-to-back issue on the done cycle is accepted.
